// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB writeback arbiter: three result FIFOs merged onto one registered bus.
// Default grant is round-robin; define CDB_ARB_FIXED_PRIO_EN for fixed priority MEM > LSB > ALU.
module cdb_arbiter #(
  parameter int ROB_SIZE_WIDTH = 5,
  parameter int REG_NUM_WIDTH  = 5,
  parameter int QUEUE_DEPTH    = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      alu_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
  input  logic [31:0]               alu_value,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] mem_rob_id,
  input  logic [31:0]               mem_value,
  output logic                      mem_ready,
  input  logic                      lsb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]               lsb_value,
  input  logic [REG_NUM_WIDTH-1:0]  lsb_dest,
  output logic                      lsb_ready,
  output logic                      cdb_valid,
  output logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
  output logic [31:0]               cdb_value,
  output logic [REG_NUM_WIDTH-1:0]  cdb_dest,
  output logic [1:0]                cdb_src
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ROB_SIZE_WIDTH-1:0] rob_id;
    logic [31:0]               value;
    logic [REG_NUM_WIDTH-1:0]  dest;
  } entry_t;

  entry_t        fifo_q [3][QUEUE_DEPTH];
  entry_t        fifo_d [3][QUEUE_DEPTH];
  logic [PW-1:0] head_q [3];
  logic [PW-1:0] head_d [3];
  logic [PW-1:0] tail_q [3];
  logic [PW-1:0] tail_d [3];
  logic [CW-1:0] count_q [3];
  logic [CW-1:0] count_d [3];

  logic                      cdb_valid_q, cdb_valid_d;
  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [31:0]               cdb_value_q, cdb_value_d;
  logic [REG_NUM_WIDTH-1:0]  cdb_dest_q, cdb_dest_d;
  logic [1:0]                cdb_src_q, cdb_src_d;

  entry_t     in_entry [3];
  entry_t     head_e;
  logic [2:0] in_valid, ready, nonempty, pop;
  logic       grant_any;
  logic [1:0] grant_src;

  // Index 0 = ALU, 1 = MEM, 2 = LSB; only LSB carries a real dest field.
  always_comb begin
    in_valid    = {lsb_valid, mem_valid, alu_valid};
    in_entry[0] = {alu_rob_id, alu_value, REG_NUM_WIDTH'(0)};
    in_entry[1] = {mem_rob_id, mem_value, REG_NUM_WIDTH'(0)};
    in_entry[2] = {lsb_rob_id, lsb_value, lsb_dest};
    for (int s = 0; s < 3; s++) begin
      ready[s]    = !rst_in && rdy_in && !flush_in && (count_q[s] < CW'(QUEUE_DEPTH));
      nonempty[s] = (count_q[s] != '0);
    end
  end

  assign alu_ready = ready[0];
  assign mem_ready = ready[1];
  assign lsb_ready = ready[2];

`ifdef CDB_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b1;
    grant_src = 2'd0;
    if (nonempty[1])      grant_src = 2'd1;
    else if (nonempty[2]) grant_src = 2'd2;
    else if (nonempty[0]) grant_src = 2'd0;
    else                  grant_any = 1'b0;
  end
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] cand;
  logic [2:0] sum;

  always_comb begin
    grant_any = 1'b0;
    grant_src = 2'd0;
    cand      = 2'd0;
    sum       = 3'd0;
    for (int k = 0; k < 3; k++) begin
      sum  = {1'b0, rr_ptr_q} + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!grant_any && nonempty[cand]) begin
        grant_any = 1'b1;
        grant_src = cand;
      end
    end
  end
`endif

  always_comb begin
    fifo_d       = fifo_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    cdb_valid_d  = 1'b0;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_value_d  = cdb_value_q;
    cdb_dest_d   = cdb_dest_q;
    cdb_src_d    = cdb_src_q;
    pop          = '0;
    head_e       = fifo_q[grant_src][head_q[grant_src]];
`ifndef CDB_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    if (rdy_in && flush_in) begin
      for (int s = 0; s < 3; s++) begin
        head_d[s]  = '0;
        tail_d[s]  = '0;
        count_d[s] = '0;
      end
`ifndef CDB_ARB_FIXED_PRIO_EN
      rr_ptr_d = 2'd0;
`endif
    end else if (rdy_in) begin
      if (grant_any) begin
        pop[grant_src]    = 1'b1;
        cdb_valid_d       = 1'b1;
        cdb_rob_id_d      = head_e.rob_id;
        cdb_value_d       = head_e.value;
        cdb_dest_d        = head_e.dest;
        cdb_src_d         = grant_src;
        head_d[grant_src] = head_q[grant_src] + PW'(1);
`ifndef CDB_ARB_FIXED_PRIO_EN
        rr_ptr_d = (grant_src == 2'd2) ? 2'd0 : grant_src + 2'd1;
`endif
      end
      // Ready comes from the registered count, so a push never relies on this cycle's pop.
      for (int s = 0; s < 3; s++) begin
        if (in_valid[s] && ready[s]) begin
          fifo_d[s][tail_q[s]] = in_entry[s];
          tail_d[s]            = tail_q[s] + PW'(1);
        end
        count_d[s] = count_q[s] + CW'(in_valid[s] && ready[s]) - CW'(pop[s]);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < 3; s++) begin
        head_q[s]  <= '0;
        tail_q[s]  <= '0;
        count_q[s] <= '0;
      end
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_dest_q   <= '0;
      cdb_src_q    <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= 2'd0;
`endif
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_value_q  <= cdb_value_d;
      cdb_dest_q   <= cdb_dest_d;
      cdb_src_q    <= cdb_src_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_dest   = cdb_dest_q;
  assign cdb_src    = cdb_src_q;
endmodule
